daddb_lane_stage: RTL

- Parametrised, pipelined successor to the blitter data-adder B-operand mux.
- Each cycle it accepts one operand command and selects, per lane, either the source-data word or a broadcast increment word (iinc/zinc low or high half).
- A new stagger mode gives lane k the value (k+1)·word, for phrase-mode Gouraud/Z stepping.
- Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so the data adder can stall without dropping operands.

---
 rtl/daddb_lane_stage_pkg.sv | 19 +
 rtl/daddb_lane_stage_if.sv | 28 ++
 rtl/daddb_lane_stage_sel.sv | 48 ++++
 rtl/daddb_lane_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/daddb_lane_stage_pkg.sv
// Shared blitter constants for the data-adder B-operand stage:
// select codes for the increment word and a lane-packing helper.
package daddb_lane_stage_pkg;

    // daddbsel[2] value that routes source data straight through
    localparam logic DADDB_SRCD = 1'b0;

    // daddbsel[1:0] codes choosing the broadcast increment half-word
    localparam logic [1:0] IINC_LO = 2'd0;
    localparam logic [1:0] IINC_HI = 2'd1;
    localparam logic [1:0] ZINC_LO = 2'd2;
    localparam logic [1:0] ZINC_HI = 2'd3;

    // Bit offset of lane 'lane' inside a lane-packed bus of width-'lw' lanes
    function automatic int unsigned laneLsb(input int unsigned lane, input int unsigned lw);
        return lane * lw;
    endfunction

endpackage

// File: rtl/daddb_lane_stage_if.sv
// Command/result bundle between the blitter front end, the B-operand
// stage and the data adder. The stage itself uses the slave view.
interface daddb_lane_stage_if #(
    parameter int LANES = 4,
    parameter int LW    = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*LW-1:0]   srcd;
    logic [2*LW-1:0]       iinc;
    logic [2*LW-1:0]       zinc;
    logic [2:0]            daddbsel;
    logic                  stagger;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*LW-1:0]   addb;
    logic                  busy;

    modport master (
        output in_valid, srcd, iinc, zinc, daddbsel, stagger, out_ready,
        input  in_ready, out_valid, addb, busy
    );

    modport slave (
        input  in_valid, srcd, iinc, zinc, daddbsel, stagger, out_ready,
        output in_ready, out_valid, addb, busy
    );
endinterface

// File: rtl/daddb_lane_stage_sel.sv
// Combinational per-lane B-operand select: source data, a broadcast
// increment word, or the staggered multiples word*(k+1) for phrase mode.
module daddb_lane_sel
    import daddb_lane_stage_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = 16
) (
    input  logic [LANES*LW-1:0] srcd_i,
    input  logic [2*LW-1:0]     iinc_i,
    input  logic [2*LW-1:0]     zinc_i,
    input  logic [2:0]          daddbsel_i,
    input  logic                stagger_i,
    output logic [LANES*LW-1:0] lanes_o
);

    logic [LW-1:0] word;
    logic [LW-1:0] acc;

    // Pick the increment half-word that is broadcast or staggered
    always_comb begin
        word = '0;
        case (daddbsel_i[1:0])
            IINC_LO: word = iinc_i[LW-1:0];
            IINC_HI: word = iinc_i[2*LW-1:LW];
            ZINC_LO: word = zinc_i[LW-1:0];
            ZINC_HI: word = zinc_i[2*LW-1:LW];
            default: word = '0;
        endcase
    end

    // Build each lane; the stagger multiples come from a running sum so no multiplier is needed, wrapping mod 2^LW
    always_comb begin
        lanes_o = '0;
        acc     = word;
        for (int k = 0; k < LANES; k++) begin
            if (daddbsel_i[2] == DADDB_SRCD) begin
                lanes_o[laneLsb(k, LW) +: LW] = srcd_i[laneLsb(k, LW) +: LW];
            end else if (stagger_i) begin
                lanes_o[laneLsb(k, LW) +: LW] = acc;
            end else begin
                lanes_o[laneLsb(k, LW) +: LW] = word;
            end
            acc = acc + word;
        end
    end

endmodule

// File: rtl/daddb_lane_stage.sv
// Pipelined data-adder B-operand stage: lane select followed by an output
// register, optionally backed by a skid entry so a stalled adder never drops
// an accepted command.
module daddb_lane_stage
    import daddb_lane_stage_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = 16,
    parameter int SKID  = 1
) (
    input logic                sys_clk,
    input logic                resetl,
    daddb_lane_stage_if.slave  bus
);

    localparam int W = LANES * LW;

    logic [W-1:0] selData;
    logic         accept;
    logic         drain;

    daddb_lane_sel #(
        .LANES (LANES),
        .LW    (LW)
    ) u_sel (
        .srcd_i     (bus.srcd),
        .iinc_i     (bus.iinc),
        .zinc_i     (bus.zinc),
        .daddbsel_i (bus.daddbsel),
        .stagger_i  (bus.stagger),
        .lanes_o    (selData)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;

    if (SKID != 0) begin : g_skid
        logic         outValid_q, outValid_d;
        logic         skidValid_q, skidValid_d;
        logic         inReady_q;
        logic [W-1:0] outData_q, outData_d;
        logic [W-1:0] skidData_q, skidData_d;

        // Next-state for output and skid slots; the skid entry always drains first to keep FIFO order
        always_comb begin
            outValid_d  = outValid_q;
            outData_d   = outData_q;
            skidValid_d = skidValid_q;
            skidData_d  = skidData_q;
            if (!outValid_q || drain) begin
                if (skidValid_q) begin
                    outValid_d  = 1'b1;
                    outData_d   = skidData_q;
                    skidValid_d = accept;
                    if (accept) begin
                        skidData_d = selData;
                    end
                end else begin
                    outValid_d = accept;
                    if (accept) begin
                        outData_d = selData;
                    end
                end
            end else if (accept) begin
                skidValid_d = 1'b1;
                skidData_d  = selData;
            end
        end

        // Slot registers; in_ready is registered from the next skid occupancy and held low through reset
        always_ff @(posedge sys_clk or negedge resetl) begin
            if (!resetl) begin
                outValid_q  <= 1'b0;
                outData_q   <= '0;
                skidValid_q <= 1'b0;
                skidData_q  <= '0;
                inReady_q   <= 1'b0;
            end else begin
                outValid_q  <= outValid_d;
                outData_q   <= outData_d;
                skidValid_q <= skidValid_d;
                skidData_q  <= skidData_d;
                inReady_q   <= !skidValid_d;
            end
        end

        assign bus.in_ready  = inReady_q;
        assign bus.out_valid = outValid_q;
        assign bus.addb      = outData_q;
        assign bus.busy      = outValid_q || skidValid_q;
    end else begin : g_reg
        logic         armed_q;
        logic         outValid_q;
        logic [W-1:0] outData_q;

        // Single output register; armed_q keeps in_ready low until the first edge after reset
        always_ff @(posedge sys_clk or negedge resetl) begin
            if (!resetl) begin
                armed_q    <= 1'b0;
                outValid_q <= 1'b0;
                outData_q  <= '0;
            end else begin
                armed_q <= 1'b1;
                if (accept) begin
                    outValid_q <= 1'b1;
                    outData_q  <= selData;
                end else if (drain) begin
                    outValid_q <= 1'b0;
                end
            end
        end

        assign bus.in_ready  = armed_q && (!outValid_q || bus.out_ready);
        assign bus.out_valid = outValid_q;
        assign bus.addb      = outData_q;
        assign bus.busy      = outValid_q;
    end

endmodule
